// File: rtl/riscv_pkg.sv
// Shared definitions for the operand fetch slice: default widths, the
// hard-wired zero register index and the forwarding source encoding.
package riscv_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 5;

  // Register x0 always reads as zero and is never a forwarding target.
  localparam int REG_X0 = 0;

  // Where an operand was taken from.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side handshake bundle of the operand fetch stage.
// master = the surrounding pipeline (drives instructions, consumes results),
// slave  = the operand fetch stage itself.
interface operand_fetch_stage_if #(
  parameter int DWIDTH = riscv_pkg::DEF_DWIDTH,
  parameter int AWIDTH = riscv_pkg::DEF_AWIDTH
);
  // upstream (decode) side
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_rs1;
  logic [AWIDTH-1:0] in_rs2;
  logic              in_rs1_used;
  logic              in_rs2_used;
  logic [AWIDTH-1:0] in_rd;
  logic              in_rd_we;
  logic              in_is_load;
  // downstream (execute) side
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_op1;
  logic [DWIDTH-1:0] out_op2;
  logic [AWIDTH-1:0] out_rd;
  logic              out_rd_we;
  logic              out_is_load;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
           in_rd, in_rd_we, in_is_load, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we, out_is_load
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
           in_rd, in_rd_we, in_is_load, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_rd_we, out_is_load
  );
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Per-operand bypass selector: x0, then EX/MEM (non-load), then WB, then
// the register file read data. Purely combinational.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic [AWIDTH-1:0] rs,
  input  logic [DWIDTH-1:0] rf_data,
  input  logic [AWIDTH-1:0] exm_rd,
  input  logic              exm_we,
  input  logic              exm_is_load,
  input  logic [DWIDTH-1:0] exm_data,
  input  logic [AWIDTH-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [DWIDTH-1:0] operand,
  output fwd_sel_t          sel
);

  // Priority select; a load in EX/MEM has no data yet so it never forwards.
  // rs==x0 is checked first, which also keeps rd=x0 producers from forwarding.
  always_comb begin
    sel     = FWD_RF;
    operand = rf_data;
    if (rs == AWIDTH'(REG_X0)) begin
      sel     = FWD_ZERO;
      operand = '0;
    end else if (exm_we && !exm_is_load && (exm_rd == rs)) begin
      sel     = FWD_EXM;
      operand = exm_data;
    end else if (wb_we && (wb_rd == rs)) begin
      // RF write lands on this edge, so RDx is still stale here.
      sel     = FWD_WB;
      operand = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives RF read addresses, resolves operands through
// two forwarding muxes, stalls on load-use and holds the result in a
// single-entry ID/EX register with valid/ready on both sides.
// Optional feature macro: OPFETCH_STALL_CNT_EN adds a saturating 32-bit
// count of hazard cycles on port stall_cnt.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  operand_fetch_stage_if.slave bus,
  output logic [AWIDTH-1:0]   RA1,
  output logic [AWIDTH-1:0]   RA2,
  input  logic [DWIDTH-1:0]   RD1,
  input  logic [DWIDTH-1:0]   RD2,
  input  logic [AWIDTH-1:0]   exm_rd,
  input  logic                exm_we,
  input  logic                exm_is_load,
  input  logic [DWIDTH-1:0]   exm_data,
  input  logic [AWIDTH-1:0]   wb_rd,
  input  logic                wb_we,
  input  logic [DWIDTH-1:0]   wb_data,
  input  logic                flush
`ifdef OPFETCH_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  logic [AWIDTH-1:0] rs_arr   [2];
  logic              used_arr [2];
  logic [DWIDTH-1:0] rf_arr   [2];
  logic [DWIDTH-1:0] op_arr   [2];
  fwd_sel_t          sel_arr  [2];
  logic [1:0]        hz_src;
  logic              hazard;
  logic              accept;

  logic              out_valid_reg, out_valid_next;
  logic [DWIDTH-1:0] out_op1_reg,   out_op1_next;
  logic [DWIDTH-1:0] out_op2_reg,   out_op2_next;
  logic [AWIDTH-1:0] out_rd_reg,    out_rd_next;
  logic              out_rd_we_reg, out_rd_we_next;
  logic              out_is_load_reg, out_is_load_next;

  assign RA1 = bus.in_rs1;
  assign RA2 = bus.in_rs2;

  assign rs_arr[0]   = bus.in_rs1;
  assign rs_arr[1]   = bus.in_rs2;
  assign used_arr[0] = bus.in_rs1_used;
  assign used_arr[1] = bus.in_rs2_used;
  assign rf_arr[0]   = RD1;
  assign rf_arr[1]   = RD2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      fwd_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwd_mux (
        .rs          (rs_arr[gi]),
        .rf_data     (rf_arr[gi]),
        .exm_rd      (exm_rd),
        .exm_we      (exm_we),
        .exm_is_load (exm_is_load),
        .exm_data    (exm_data),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .wb_data     (wb_data),
        .operand     (op_arr[gi]),
        .sel         (sel_arr[gi])
      );
      // Load-use check for this source; FWD_ZERO means rs is x0, which never stalls.
      assign hz_src[gi] = used_arr[gi] && (sel_arr[gi] != FWD_ZERO) &&
                          ((out_valid_reg && out_is_load_reg && out_rd_we_reg &&
                            (out_rd_reg == rs_arr[gi])) ||
                           (exm_we && exm_is_load && (exm_rd == rs_arr[gi])));
    end
  endgenerate

  assign hazard       = bus.in_valid && (|hz_src);
  assign bus.in_ready = !flush && !hazard && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Next ID/EX contents: flush kills, accept loads, drain empties, else hold.
  always_comb begin
    out_valid_next   = out_valid_reg;
    out_op1_next     = out_op1_reg;
    out_op2_next     = out_op2_reg;
    out_rd_next      = out_rd_reg;
    out_rd_we_next   = out_rd_we_reg;
    out_is_load_next = out_is_load_reg;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (accept) begin
      out_valid_next   = 1'b1;
      out_op1_next     = op_arr[0];
      out_op2_next     = op_arr[1];
      out_rd_next      = bus.in_rd;
      out_rd_we_next   = bus.in_rd_we;
      out_is_load_next = bus.in_is_load;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // ID/EX register; reset wins over flush and the handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_reg   <= 1'b0;
      out_op1_reg     <= '0;
      out_op2_reg     <= '0;
      out_rd_reg      <= '0;
      out_rd_we_reg   <= 1'b0;
      out_is_load_reg <= 1'b0;
    end else begin
      out_valid_reg   <= out_valid_next;
      out_op1_reg     <= out_op1_next;
      out_op2_reg     <= out_op2_next;
      out_rd_reg      <= out_rd_next;
      out_rd_we_reg   <= out_rd_we_next;
      out_is_load_reg <= out_is_load_next;
    end
  end

  assign bus.out_valid   = out_valid_reg;
  assign bus.out_op1     = out_op1_reg;
  assign bus.out_op2     = out_op2_reg;
  assign bus.out_rd      = out_rd_reg;
  assign bus.out_rd_we   = out_rd_we_reg;
  assign bus.out_is_load = out_is_load_reg;

`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of cycles in which a load-use hazard blocks the input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_reg <= '0;
    end else if (hazard && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a behavioural model. Honours OPFETCH_STALL_CNT_EN when defined.
module tb_operand_fetch_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] RA1, RA2;
  logic [DW-1:0] RD1 = '0, RD2 = '0;
  logic [AW-1:0] exm_rd = '0, wb_rd = '0;
  logic          exm_we = 1'b0, exm_is_load = 1'b0, wb_we = 1'b0, flush = 1'b0;
  logic [DW-1:0] exm_data = '0, wb_data = '0;
`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  operand_fetch_stage_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  operand_fetch_stage #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_data(exm_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .flush(flush)
`ifdef OPFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit verbose = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // What the ID/EX register should hold, as the execute stage sees it.
  bit          m_live = 1'b0;
  bit          m_valid = 1'b0, m_we = 1'b0, m_ld = 1'b0;
  logic [31:0] m_op1 = '0, m_op2 = '0;
  logic [4:0]  m_rd = '0;
  longint      m_stalls = 0;

  // Value an instruction reading register rs must see right now.
  function automatic logic [31:0] value_of(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (exm_we && !exm_is_load && exm_rd == rs) return exm_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // True when rs is produced by a load whose data is not yet available.
  function automatic bit waits_on_load(input logic [4:0] rs, input logic used);
    bit in_idex, in_exm;
    if (!used || rs == 0) return 1'b0;
    in_idex = m_valid && m_ld && m_we && (m_rd == rs);
    in_exm  = exm_we && exm_is_load && (exm_rd == rs);
    return in_idex || in_exm;
  endfunction

  // Compare every cycle on the falling edge, then advance the model to what
  // the coming rising edge must produce.
  initial begin
    bit hz, rdy;
    forever begin
      @(negedge CLK);
      hz  = bus.in_valid && (waits_on_load(bus.in_rs1, bus.in_rs1_used) ||
                             waits_on_load(bus.in_rs2, bus.in_rs2_used));
      rdy = !flush && !hz && (!m_valid || bus.out_ready);
      if (m_live) begin
        chk("ra1", {27'd0, RA1}, {27'd0, bus.in_rs1});
        chk("ra2", {27'd0, RA2}, {27'd0, bus.in_rs2});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
          chk("out_op1", bus.out_op1, m_op1);
          chk("out_op2", bus.out_op2, m_op2);
          chk("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
          chk("out_rd_we", {31'd0, bus.out_rd_we}, {31'd0, m_we});
          chk("out_is_load", {31'd0, bus.out_is_load}, {31'd0, m_ld});
        end
`ifdef OPFETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stalls[31:0]);
`endif
      end
      if (RST) begin
        m_valid = 0; m_we = 0; m_ld = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_stalls = 0;
        m_live = 1'b1;
      end else begin
        if (hz) m_stalls++;
        if (flush) m_valid = 0;
        else if (bus.in_valid && rdy) begin
          m_op1 = value_of(bus.in_rs1, RD1);
          m_op2 = value_of(bus.in_rs2, RD2);
          m_rd = bus.in_rd; m_we = bus.in_rd_we; m_ld = bus.in_is_load; m_valid = 1;
          if (verbose)
            $display("[TB] accept rd=%0d we=%0d ld=%0d op1=0x%08h op2=0x%08h",
                     m_rd, m_we, m_ld, m_op1, m_op2);
        end else if (bus.out_ready) m_valid = 0;
      end
    end
  end

  task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    bus.in_valid = 1'b1;
    bus.in_rs1 = rs1; bus.in_rs1_used = u1;
    bus.in_rs2 = rs2; bus.in_rs2_used = u2;
    bus.in_rd = rd; bus.in_rd_we = we; bus.in_is_load = ld;
  endtask

  task automatic check_ready(input string name, input logic exp);
    @(negedge CLK);
    chk(name, {31'd0, bus.in_ready}, {31'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rs1_used = 0;
    bus.in_rs2_used = 0; bus.in_rd = 0; bus.in_rd_we = 0; bus.in_is_load = 0;
    bus.out_ready = 1;
    RST = 1;
    step(); step();
    RST = 0;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_op1", bus.out_op1, 32'd0);
    chk("rst_op2", bus.out_op2, 32'd0);
    chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);
`ifdef OPFETCH_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // no hazard, plain RF read
    set_instr(5'd2, 1, 5'd3, 1, 5'd9, 1, 0);
    RD1 = 32'hF00; RD2 = 32'h100;
    check_ready("t1_ready", 1'b1);
    step();
    chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_op1", bus.out_op1, 32'hF00);
    chk("t1_op2", bus.out_op2, 32'h100);

    // forwarding priority on x5
    set_instr(5'd5, 1, 5'd0, 0, 5'd10, 1, 0);
    exm_we = 1; exm_rd = 5; exm_is_load = 0; exm_data = 32'hAA;
    wb_we = 1; wb_rd = 5; wb_data = 32'hBB; RD1 = 32'h55;
    step();
    chk("t2_exm", bus.out_op1, 32'hAA);
    exm_we = 0;
    step();
    chk("t2_wb", bus.out_op1, 32'hBB);
    bus.in_rs1 = 0;
    step();
    chk("t2_x0", bus.out_op1, 32'h0);
    wb_we = 0; bus.in_valid = 0;
    step();

    // load-use on x7: two bubbles, then issue with wb_data
    RST = 1; step(); RST = 0;
    set_instr(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    chk("t3_load_valid", {31'd0, bus.out_is_load}, 32'd1);
    set_instr(5'd0, 0, 5'd7, 1, 5'd8, 1, 0);
    RD2 = 32'hDEAD;
    check_ready("t3_ready_c1", 1'b0);
    step();
    exm_we = 1; exm_rd = 7; exm_is_load = 1; exm_data = 32'h9999;
    chk("t3_bubble1", {31'd0, bus.out_valid}, 32'd0);
    check_ready("t3_ready_c2", 1'b0);
    step();
    exm_we = 0; exm_is_load = 0; wb_we = 1; wb_rd = 7; wb_data = 32'h1234;
    chk("t3_bubble2", {31'd0, bus.out_valid}, 32'd0);
    check_ready("t3_ready_c3", 1'b1);
    step();
    wb_we = 0;
    chk("t3_issue_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t3_issue_op2", bus.out_op2, 32'h1234);
`ifdef OPFETCH_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, 32'd2);
`endif

    // backpressure for three cycles
    set_instr(5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
    RD1 = 32'h11; RD2 = 32'h22; bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check_ready("t4_ready_hold", 1'b0);
      step();
      chk("t4_hold_op2", bus.out_op2, 32'h1234);
      chk("t4_hold_rd", {27'd0, bus.out_rd}, 32'd8);
    end
    bus.out_ready = 1;
    check_ready("t4_ready_release", 1'b1);
    step();
    chk("t4_new_op1", bus.out_op1, 32'h11);
    chk("t4_new_rd", {27'd0, bus.out_rd}, 32'd9);

    // flush while holding, then flush with in_valid on an empty stage
    bus.out_ready = 0; flush = 1;
    check_ready("t5_ready_flush", 1'b0);
    step();
    chk("t5_flush_hold", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1;
    step();
    chk("t5_flush_accept", {31'd0, bus.out_valid}, 32'd0);
    flush = 0;

    // reset in the middle of a load-use stall while holding
    set_instr(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    step();
    set_instr(5'd7, 1, 5'd0, 0, 5'd3, 1, 0);
    bus.out_ready = 0;
    step();
    RST = 1;
    step();
    RST = 0;
    chk("t6_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_op1", bus.out_op1, 32'd0);
    chk("t6_op2", bus.out_op2, 32'd0);
    chk("t6_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("t6_we", {31'd0, bus.out_rd_we}, 32'd0);
    chk("t6_ld", {31'd0, bus.out_is_load}, 32'd0);
`ifdef OPFETCH_STALL_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif

    // randomized traffic, small index range so matches are frequent
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid    = ($urandom_range(0, 9) < 7);
      bus.in_rs1      = 5'($urandom_range(0, 7));
      bus.in_rs2      = 5'($urandom_range(0, 7));
      bus.in_rs1_used = 1'($urandom_range(0, 1));
      bus.in_rs2_used = 1'($urandom_range(0, 1));
      bus.in_rd       = 5'($urandom_range(0, 7));
      bus.in_rd_we    = 1'($urandom_range(0, 1));
      bus.in_is_load  = ($urandom_range(0, 3) == 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      RD1 = $urandom; RD2 = $urandom;
      exm_rd = 5'($urandom_range(0, 7)); exm_we = 1'($urandom_range(0, 1));
      exm_is_load = ($urandom_range(0, 3) == 0); exm_data = $urandom;
      wb_rd = 5'($urandom_range(0, 7)); wb_we = 1'($urandom_range(0, 1));
      wb_data = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      RST   = ($urandom_range(0, 49) == 0);
      step();
    end
    RST = 0; flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute operand stage that sits directly downstream of the register file. It drives the register file read addresses and consumes the asynchronous read data. It resolves RAW hazards by forwarding from the EX/MEM and WB stages, and inserts bubbles on load-use dependencies. The resolved operands are latched into a single-entry ID/EX pipeline register with valid/ready handshakes on both sides.

## Interface
- DWIDTH, 32, data width
- AWIDTH, 5, register address width
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  AWIDTH  source register indices
- in_rs1_used, in_rs2_used  in  1  operand actually read (gates hazard check)
- in_rd  in  AWIDTH  destination index
- in_rd_we  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- RA1, RA2  out  AWIDTH  register file read addresses (= in_rs1, in_rs2, combinational)
- RD1, RD2  in  DWIDTH  register file read data
- exm_rd, exm_we, exm_is_load, exm_data  in  AWIDTH/1/1/DWIDTH  EX/MEM stage result
- wb_rd, wb_we, wb_data  in  AWIDTH/1/DWIDTH  WB stage write (same values drive the register file write port)
- flush  in  1  kill stage contents
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX stage accepts
- out_op1, out_op2  out  DWIDTH  resolved operands
- out_rd, out_rd_we, out_is_load  out  AWIDTH/1/1  forwarded control

## Operation
- Operand select per source, priority order:
  - index 0 gives 0.
  - exm_we && exm_rd==rs && !exm_is_load gives exm_data.
  - wb_we && wb_rd==rs gives wb_data.
  - Otherwise RDx.
- The register file write lands on the clock edge, so a same-cycle WB match must use wb_data.
- hazard = in_valid && for any used rs≠0:
  - (out_valid && out_is_load && out_rd_we && out_rd==rs), or
  - (exm_we && exm_is_load && exm_rd==rs).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept when in_valid && in_ready: the ID/EX register loads the selected operands and control, and out_valid=1.
- Drain without accept (out_ready=1, no accept): out_valid=0. This produces the bubble.
- Hold when out_valid && !out_ready: all outputs stable, no new accept.
- flush: out_valid=0 next cycle. flush overrides accept and hold.
- Load-use costs two bubble cycles: load in ID/EX, then load in EX/MEM; the dependent instruction issues with wb_data.

## Timing
- Latency 1 cycle: accept in cycle N gives outputs valid in N+1, with operands sampled at N.
- RA1/RA2 are combinational from the inputs with zero latency.
- Reset values: out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_we=0, out_is_load=0, stall_cnt=0.
- RST has priority over flush and over the handshake.
- RST mid-hold discards the held instruction.
- rd=0 never forwards and never causes a hazard, even when the *_we signal is 1.

## Configuration
- OPFETCH_STALL_CNT_EN defined:
  - Adds output stall_cnt (32 bits), a saturating count of cycles with hazard=1.
  - Reset to 0 on RST.
  - Holds at 0xFFFFFFFF once reached.
- OPFETCH_STALL_CNT_EN undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package riscv_pkg contains:
  - DWIDTH and AWIDTH defaults
  - REG_X0 constant
  - fwd_sel_t enum: FWD_ZERO, FWD_EXM, FWD_WB, FWD_RF
- Sub-module fwd_mux, instantiated twice (one per operand):
  - Inputs: rs, rf data, EX/MEM and WB buses.
  - Outputs: operand and fwd_sel_t.
  - Purely combinational.
- Hazard detection and the ID/EX register live in the top module.

## Test plan
- No hazard: rs1=2, rs2=3, RD1=0xF00, RD2=0x100, no forwards → next cycle out_op1=0xF00, out_op2=0x100, out_valid=1.
- EX/MEM and WB both target x5 (exm_data=0xAA, wb_data=0xBB), rs1=5 → out_op1=0xAA. With exm_we=0 → 0xBB. With rs1=0 → 0.
- Load x7 in ID/EX, next instruction uses rs2=7:
  - in_ready=0 for 2 cycles, with out_valid=0 bubbles.
  - Then the instruction is accepted with op2=wb_data=0x1234.
  - stall_cnt=2 when the macro is defined.
- Backpressure: out_ready=0 for 3 cycles → outputs unchanged, in_ready=0. out_ready=1 → next instruction accepted in the same cycle.
- flush while holding, and simultaneously with in_valid → out_valid=0 next cycle and the instruction is not accepted. RST asserted mid-stall → all outputs 0 next cycle.
